// File: rtl/regbank_seq_ctrl.sv
// Sequencing initiator for a 2-read/1-write register bank: accept, read, execute, write back.
// Optional macro REGBANK_SEQ_CTRL_R0_ZERO_EN makes register 0 read as zero and suppresses writes to it.
module regbank_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_sr1,
  input  logic [ADDR_W-1:0] in_sr2,
  input  logic [ADDR_W-1:0] in_dr,
  input  logic [DATA_W-1:0] in_imm,
  output logic [ADDR_W-1:0] sr1,
  output logic [ADDR_W-1:0] sr2,
  input  logic [DATA_W-1:0] rdData1,
  input  logic [DATA_W-1:0] rdData2,
  output logic [ADDR_W-1:0] dr,
  output logic [DATA_W-1:0] wrData,
  output logic              write,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t              r_state;
  logic [2:0]          r_op;
  logic [ADDR_W-1:0]   r_dr;
  logic [DATA_W-1:0]   r_imm;
  logic [DATA_W-1:0]   r_opa;
  logic [DATA_W-1:0]   r_opb;
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_rd2;
  logic [DATA_W-1:0]   w_alu;
  logic                w_wr_en;

  always_comb begin
    w_rd1   = rdData1;
    w_rd2   = rdData2;
    w_wr_en = 1'b1;
`ifdef REGBANK_SEQ_CTRL_R0_ZERO_EN
    if (sr1 == '0) w_rd1 = '0;
    if (sr2 == '0) w_rd2 = '0;
    if (r_dr == '0) w_wr_en = 1'b0;
`endif
  end

  always_comb begin
    w_alu = '0;
    case (r_op)
      3'd0:    w_alu = r_opa + r_opb;
      3'd1:    w_alu = r_opa - r_opb;
      3'd2:    w_alu = r_opa & r_opb;
      3'd3:    w_alu = r_opa | r_opb;
      3'd4:    w_alu = r_opa ^ r_opb;
      3'd5:    w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_opa) < $signed(r_opb))};
      3'd6:    w_alu = r_opa << r_opb[4:0];
      default: w_alu = r_imm;
    endcase
  end

  // write/done are set on the EXEC edge so they are high exactly during the WRITE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      in_ready <= 1'b1;
      write    <= 1'b0;
      done     <= 1'b0;
      sr1      <= '0;
      sr2      <= '0;
      dr       <= '0;
      wrData   <= '0;
      result   <= '0;
      retired  <= '0;
      r_op     <= '0;
      r_dr     <= '0;
      r_imm    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_op     <= in_op;
            sr1      <= in_sr1;
            sr2      <= in_sr2;
            r_dr     <= in_dr;
            r_imm    <= in_imm;
            in_ready <= 1'b0;
            r_state  <= READ;
          end
        end
        READ: begin
          r_opa   <= w_rd1;
          r_opb   <= w_rd2;
          r_state <= EXEC;
        end
        EXEC: begin
          result  <= w_alu;
          wrData  <= w_alu;
          write   <= w_wr_en;
          dr      <= r_dr;
          done    <= 1'b1;
          r_state <= WRITE;
        end
        WRITE: begin
          write    <= 1'b0;
          done     <= 1'b0;
          retired  <= retired + CNT_W'(1);
          in_ready <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_seq_ctrl.sv
// Bench for regbank_seq_ctrl: behavioural register bank, model register file and result scoreboard.
// Define REGBANK_SEQ_CTRL_R0_ZERO_EN for both files to exercise the zero-register variant.
module tb_regbank_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_sr1, in_sr2, in_dr;
  logic [31:0] in_imm;
  logic [4:0]  sr1, sr2, dr;
  logic [31:0] rdData1, rdData2, wrData, result;
  logic        write, done;
  logic [15:0] retired;

  regbank_seq_ctrl #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr), .in_imm(in_imm),
    .sr1(sr1), .sr2(sr2), .rdData1(rdData1), .rdData2(rdData2),
    .dr(dr), .wrData(wrData), .write(write), .done(done),
    .result(result), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] bank [32];
  logic        bank_init;
  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < 32; i++) bank[i] <= 32'hA5A5_0000 + 32'(i);
    end else if (write) begin
      bank[dr] <= wrData;
    end
  end
  assign rdData1 = bank[sr1];
  assign rdData2 = bank[sr2];

  typedef struct {
    logic [31:0] res;
    logic [4:0]  d;
    logic        wexp;
  } sb_t;
  sb_t         sb_q[$];
  logic [31:0] ref_rf [32];
  logic [15:0] exp_ret;
  int          n_pass;
  int          n_total;

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
`ifdef REGBANK_SEQ_CTRL_R0_ZERO_EN
    if (a == 5'd0) return 32'd0;
`endif
    return ref_rf[a];
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << sh;
      default: return imm;
    endcase
  endfunction

  function automatic logic ref_wen(input logic [4:0] d);
`ifdef REGBANK_SEQ_CTRL_R0_ZERO_EN
    return d != 5'd0;
`else
    return (d == d);
`endif
  endfunction

  // Pushes the expected outcome for an instruction about to be accepted and updates the model register file.
  task automatic sb_push(input logic [2:0] op, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic [31:0] imm);
    sb_t e;
    e.res  = ref_alu(op, ref_rd(s1), ref_rd(s2), imm);
    e.d    = d;
    e.wexp = ref_wen(d);
    sb_q.push_back(e);
    if (e.wexp) ref_rf[d] = e.res;
    exp_ret = exp_ret + 16'd1;
  endtask

  task automatic do_instr(input string nm, input logic [2:0] op, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [4:0] d, input logic [31:0] imm);
    int   waitc;
    int   wcount;
    bit   seen;
    sb_t  e;
    logic [15:0] ret_exp;
    waitc = 0;
    while (!in_ready && waitc < 20) begin @(negedge clk); waitc++; end
    if (!in_ready) begin
      n_total++;
      $display("FAIL %s ready_timeout: in_ready=%0b required 1", nm, in_ready);
      return;
    end
    sb_push(op, s1, s2, d, imm);
    ret_exp = exp_ret;
    in_op = op; in_sr1 = s1; in_sr2 = s2; in_dr = d; in_imm = imm; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wcount = 0;
    seen = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (write) wcount++;
      if (done) begin
        seen = 1'b1;
        n_total++;
        if (k !== 3) $display("FAIL %s latency: done at %0d required 3", nm, k);
        else n_pass++;
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL %s sb_empty: queue size 0 required 1", nm);
        end else begin
          e = sb_q.pop_front();
          n_total++;
          if (result !== e.res) $display("FAIL %s result: got %h required %h", nm, result, e.res);
          else n_pass++;
          n_total++;
          if (wrData !== e.res) $display("FAIL %s wrData: got %h required %h", nm, wrData, e.res);
          else n_pass++;
          n_total++;
          if (dr !== e.d) $display("FAIL %s dr: got %0d required %0d", nm, dr, e.d);
          else n_pass++;
          n_total++;
          if (write !== e.wexp) $display("FAIL %s write: got %0b required %0b", nm, write, e.wexp);
          else n_pass++;
        end
      end
      if (k == 4) begin
        n_total++;
        if (in_ready !== 1'b1 || retired !== ret_exp)
          $display("FAIL %s post_state: ready=%0b retired=%0d required ready=1 retired=%0d",
                   nm, in_ready, retired, ret_exp);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_total++;
    if (!seen) begin
      $display("FAIL %s done_missing: done seen 0 required 1", nm);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end else n_pass++;
    n_total++;
    if (wcount !== (ref_wen(d) ? 1 : 0))
      $display("FAIL %s write_cycles: got %0d required %0d", nm, wcount, ref_wen(d) ? 1 : 0);
    else n_pass++;
    n_total++;
    if (bank[d] !== ref_rf[d]) $display("FAIL %s bank[%0d]: got %h required %h", nm, d, bank[d], ref_rf[d]);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; bank_init = 1'b1; in_valid = 1'b0;
    in_op = '0; in_sr1 = '0; in_sr2 = '0; in_dr = '0; in_imm = '0;
    repeat (2) @(negedge clk);
    bank_init = 1'b0;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'hA5A5_0000 + 32'(i);
    exp_ret = '0;
    n_total++;
    if (in_ready !== 1'b1 || write !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_ctrl: ready=%0b write=%0b done=%0b required 1 0 0", in_ready, write, done);
    else n_pass++;
    n_total++;
    if (retired !== 16'd0 || result !== 32'd0 || wrData !== 32'd0)
      $display("FAIL reset_data: retired=%0d result=%h wrData=%h required 0 0 0", retired, result, wrData);
    else n_pass++;
    n_total++;
    if (sr1 !== 5'd0 || sr2 !== 5'd0 || dr !== 5'd0)
      $display("FAIL reset_addr: sr1=%0d sr2=%0d dr=%0d required 0 0 0", sr1, sr2, dr);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ldi_add();
    do_instr("ldi_r1", 3'd7, 5'd0, 5'd0, 5'd1, 32'd10);
    do_instr("ldi_r2", 3'd7, 5'd0, 5'd0, 5'd2, 32'd3);
    do_instr("add_r3", 3'd0, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF);
    n_total++;
    if (bank[3] !== 32'd13 || result !== 32'd13 || retired !== 16'd3)
      $display("FAIL add_const: r3=%h result=%h retired=%0d required 13 13 3", bank[3], result, retired);
    else n_pass++;
  endtask

  task automatic test_ops();
    do_instr("sub_r4", 3'd1, 5'd2, 5'd1, 5'd4, 32'd0);
    do_instr("slt_r5", 3'd5, 5'd4, 5'd1, 5'd5, 32'd0);
    do_instr("sll_r6", 3'd6, 5'd2, 5'd2, 5'd6, 32'd0);
    n_total++;
    if (bank[4] !== 32'hFFFF_FFF9 || bank[5] !== 32'd1 || bank[6] !== 32'd24)
      $display("FAIL ops_const: r4=%h r5=%h r6=%h required fffffff9 1 18", bank[4], bank[5], bank[6]);
    else n_pass++;
    do_instr("slt_signed", 3'd5, 5'd1, 5'd4, 5'd8, 32'd0);
    do_instr("and_r10", 3'd2, 5'd4, 5'd3, 5'd10, 32'd0);
    do_instr("or_r11", 3'd3, 5'd1, 5'd2, 5'd11, 32'd0);
    do_instr("xor_r12", 3'd4, 5'd4, 5'd1, 5'd12, 32'd0);
    do_instr("add_wrap", 3'd0, 5'd4, 5'd1, 5'd13, 32'd0);
    do_instr("sll_mask", 3'd6, 5'd2, 5'd4, 5'd14, 32'd0);
    n_total++;
    if (bank[8] !== 32'd0 || bank[13] !== 32'd3 || bank[14] !== 32'h0600_0000)
      $display("FAIL ops_edge: r8=%h r13=%h r14=%h required 0 3 06000000", bank[8], bank[13], bank[14]);
    else n_pass++;
    do_instr("dr_eq_sr", 3'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    n_total++;
    if (bank[1] !== 32'd20) $display("FAIL dr_eq_sr_const: r1=%h required 14", bank[1]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int  acc;
    int  low;
    int  dn;
    int  t_acc [3];
    sb_t e;
    acc = 0; low = 0; dn = 0;
    in_op = 3'd7; in_sr1 = 5'd0; in_sr2 = 5'd0; in_dr = 5'd9;
    for (int t = 0; t < 12; t++) begin
      in_imm = 32'h100 + 32'(t);
      in_valid = 1'b1;
      if (done) begin
        dn++;
        n_total++;
        if (sb_q.size() == 0) $display("FAIL b2b_sb_empty: queue size 0 required 1");
        else begin
          e = sb_q.pop_front();
          if (result !== e.res) $display("FAIL b2b_result: got %h required %h", result, e.res);
          else n_pass++;
        end
      end
      if (in_ready) begin
        if (acc < 3) t_acc[acc] = t;
        acc++;
        sb_push(3'd7, 5'd0, 5'd0, 5'd9, in_imm);
      end else low++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_total++;
    if (acc !== 3) $display("FAIL b2b_accepts: got %0d required 3", acc);
    else n_pass++;
    n_total++;
    if (acc == 3 && (t_acc[1] - t_acc[0] !== 4 || t_acc[2] - t_acc[1] !== 4))
      $display("FAIL b2b_spacing: got %0d,%0d required 4,4", t_acc[1] - t_acc[0], t_acc[2] - t_acc[1]);
    else if (acc == 3) n_pass++;
    n_total++;
    if (low !== 9) $display("FAIL b2b_ready_low: got %0d required 9", low);
    else n_pass++;
    n_total++;
    if (dn !== 3 || retired !== exp_ret || bank[9] !== 32'h108)
      $display("FAIL b2b_end: dones=%0d retired=%0d r9=%h required 3 %0d 108", dn, retired, bank[9], exp_ret);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] old7;
    int          wseen;
    old7 = bank[7];
    in_op = 3'd0; in_sr1 = 5'd1; in_sr2 = 5'd2; in_dr = 5'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_ret = '0;
    n_total++;
    if (in_ready !== 1'b1 || write !== 1'b0 || done !== 1'b0 || retired !== 16'd0 || result !== 32'd0)
      $display("FAIL mid_reset_state: ready=%0b write=%0b done=%0b retired=%0d result=%h required 1 0 0 0 0",
               in_ready, write, done, retired, result);
    else n_pass++;
    wseen = 0;
    for (int k = 0; k < 4; k++) begin
      if (write || done) wseen++;
      @(negedge clk);
    end
    n_total++;
    if (wseen !== 0 || bank[7] !== old7)
      $display("FAIL mid_reset_nowrite: pulses=%0d r7=%h required 0 %h", wseen, bank[7], old7);
    else n_pass++;
  endtask

  task automatic test_r0();
    logic [31:0] exp6;
    do_instr("ldi_r0", 3'd7, 5'd0, 5'd0, 5'd0, 32'd5);
    do_instr("ldi_r1b", 3'd7, 5'd0, 5'd0, 5'd1, 32'd10);
    do_instr("add_r0r1", 3'd0, 5'd0, 5'd1, 5'd6, 32'd0);
`ifdef REGBANK_SEQ_CTRL_R0_ZERO_EN
    exp6 = 32'd10;
`else
    exp6 = 32'd15;
`endif
    n_total++;
    if (bank[6] !== exp6 || retired !== 16'd3)
      $display("FAIL r0_const: r6=%h retired=%0d required %h 3", bank[6], retired, exp6);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    test_reset();
    test_ldi_add();
    test_ops();
    test_back_to_back();
    test_reset_mid();
    test_r0();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
